// File: rtl/clock_time_setter.sv
// Time-setting controller: captures the live time, edits H/M/S with up/down, commits with a one-cycle load strobe.
// Optional auto-cancel on inactivity is compiled in with `define CLOCK_SETTER_TIMEOUT_EN.
module clock_time_setter #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_cancel,
   input  logic [4:0] cur_hours,
   input  logic [5:0] cur_mins,
   input  logic [5:0] cur_secs,
   output logic [4:0] hours_o,
   output logic [5:0] mins_o,
   output logic [5:0] secs_o,
   output logic       start_o,
   output logic       setting_o,
   output logic [1:0] field_o
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SET_H  = 3'd1;
   localparam logic [2:0] SET_M  = 3'd2;
   localparam logic [2:0] SET_S  = 3'd3;
   localparam logic [2:0] COMMIT = 3'd4;

   logic [2:0] state;
   logic [2:0] next_state;
   logic [1:0] field_next;
   logic       editing;
   logic       any_btn;
   logic       step_up;
   logic       step_down;
   logic       timeout_hit;

   assign editing   = (state == SET_H) || (state == SET_M) || (state == SET_S);
   assign any_btn   = btn_mode | btn_up | btn_down | btn_cancel;
   assign step_up   = btn_up & ~btn_down;
   assign step_down = btn_down & ~btn_up;

   function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max_v,
                                            input logic up);
      if (up)
         return (v >= max_v) ? 6'd0 : v + 6'd1;
      else
         return (v == 6'd0) ? max_v : v - 6'd1;
   endfunction

`ifdef CLOCK_SETTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;

   // Any button press restarts the inactivity window; expiry fires on the last quiet cycle.
   assign timeout_hit = editing && !any_btn && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         idle_cnt <= '0;
      else if (editing && !any_btn && !timeout_hit)
         idle_cnt <= idle_cnt + TW'(1);
      else
         idle_cnt <= '0;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0) & any_btn;
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (btn_mode) next_state = SET_H;
         SET_H:   if (btn_cancel) next_state = IDLE;
                  else if (btn_mode) next_state = SET_M;
                  else if (timeout_hit) next_state = IDLE;
         SET_M:   if (btn_cancel) next_state = IDLE;
                  else if (btn_mode) next_state = SET_S;
                  else if (timeout_hit) next_state = IDLE;
         SET_S:   if (btn_cancel) next_state = IDLE;
                  else if (btn_mode) next_state = COMMIT;
                  else if (timeout_hit) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      field_next = 2'd0;
      case (next_state)
         SET_H:   field_next = 2'd1;
         SET_M:   field_next = 2'd2;
         SET_S:   field_next = 2'd3;
         default: field_next = 2'd0;
      endcase
   end

   // Status outputs are decoded from the next state so they line up with the registered state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         start_o   <= 1'b0;
         setting_o <= 1'b0;
         field_o   <= 2'd0;
      end else begin
         state     <= next_state;
         start_o   <= (next_state == COMMIT);
         setting_o <= (field_next != 2'd0);
         field_o   <= field_next;
      end
   end

   // Edit registers double as the load-side outputs; cancel leaves them as they were.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hours_o <= 5'd0;
         mins_o  <= 6'd0;
         secs_o  <= 6'd0;
      end else if (state == IDLE && btn_mode) begin
         hours_o <= (cur_hours > 5'd23) ? 5'd0 : cur_hours;
         mins_o  <= (cur_mins > 6'd59) ? 6'd0 : cur_mins;
         secs_o  <= (cur_secs > 6'd59) ? 6'd0 : cur_secs;
      end else if (editing && !btn_cancel && !btn_mode && (step_up || step_down)) begin
         case (state)
            SET_H:   hours_o <= 5'(wrap_step({1'b0, hours_o}, 6'd23, step_up));
            SET_M:   mins_o  <= wrap_step(mins_o, 6'd59, step_up);
            default: secs_o  <= wrap_step(secs_o, 6'd59, step_up);
         endcase
      end
   end

endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
- User-facing controller that drives the load side of the 24-hour clock counter: its time-value outputs and its one-cycle load strobe.
- Captures the running time, lets the user edit hours, minutes and seconds in turn with up/down buttons, then commits the edited time with a one-cycle start pulse.
- Sits between the debounced button logic and the clock counter.

Parameters:
TIMEOUT_CYCLES, 1000, idle cycles in any edit state before automatic cancel (used only when the optional feature is compiled in).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
btn_mode  input  1  one-cycle pulse; enter edit mode / advance field / commit
btn_up  input  1  one-cycle pulse; increment selected field
btn_down  input  1  one-cycle pulse; decrement selected field
btn_cancel  input  1  one-cycle pulse; abandon edit, no load
cur_hours  input  5  live hours from clock counter (0-23)
cur_mins  input  6  live minutes from clock counter (0-59)
cur_secs  input  6  live seconds from clock counter (0-59)
hours_o  output  5  edited hours, to counter load input
mins_o  output  6  edited minutes, to counter load input
secs_o  output  6  edited seconds, to counter load input
start_o  output  1  load strobe to counter, exactly one cycle per commit
setting_o  output  1  high while in any edit state
field_o  output  2  field being edited: 0 none, 1 hours, 2 mins, 3 secs

Behaviour:
- Reset, asynchronous and active-low: state IDLE; hours_o, mins_o, secs_o = 0; start_o = 0; setting_o = 0; field_o = 0; timeout counter cleared. Reset asserted mid-edit discards the edit and produces no start pulse.
- All outputs are registered.
- States and transitions:
  - IDLE: btn_mode -> SET_H, loading the edit registers from cur_hours, cur_mins and cur_secs on the same edge. btn_up, btn_down and btn_cancel are ignored.
  - SET_H: btn_mode -> SET_M.
  - SET_M: btn_mode -> SET_S.
  - SET_S: btn_mode -> COMMIT.
  - COMMIT: start_o = 1 for exactly this one cycle; hours_o, mins_o and secs_o hold the edited values; next state IDLE unconditionally. All buttons are ignored in COMMIT.
  - btn_cancel in SET_H, SET_M or SET_S -> IDLE with no start pulse. The edit registers keep their last values.
- Input priority per cycle: btn_cancel > btn_mode > btn_up/btn_down. A lower-priority press in the same cycle is dropped.
- btn_up and btn_down asserted together: no change.
- Arithmetic, applied to the selected field only:
  - Hours: up wraps 23 -> 0; down wraps 0 -> 23.
  - Minutes and seconds: up wraps 59 -> 0; down wraps 0 -> 59.
  - Out-of-range values on cur_* (e.g. hours 31) are clamped to 0 at capture.
- setting_o = 1 in SET_H, SET_M and SET_S; 0 in IDLE and COMMIT.
- field_o = 1, 2, 3 in SET_H, SET_M, SET_S respectively; 0 otherwise.
- Latency: button pulse to updated output is 1 cycle. btn_mode in SET_S produces start_o on the next cycle. The counter loads on the edge that ends the COMMIT cycle.

Optional Feature:
CLOCK_SETTER_TIMEOUT_EN
- Defined:
  - A counter clears on entry to SET_H and on any button pulse while in an edit state, and increments on every other edit-state cycle.
  - When it reaches TIMEOUT_CYCLES, the block returns to IDLE with no start pulse, exactly like btn_cancel.
  - A button pulse on the expiry cycle takes precedence over the timeout.
- Undefined: no counter is built; edit states are held indefinitely.

Test Plan:
- Reset, then cur = 13:45:30 and btn_mode -> next cycle field_o = 1, setting_o = 1, outputs 13:45:30.
- In SET_H at hours 23, btn_up -> hours_o = 0. Then btn_down -> hours_o = 23. In SET_M at mins 0, btn_down -> mins_o = 59.
- Full sequence: capture 10:20:30, up in SET_H, down twice in SET_M, up in SET_S, then mode three times -> start_o high exactly one cycle with 11:18:31; setting_o = 0 afterwards.
- btn_cancel in SET_M -> IDLE, start_o never asserted, field_o = 0.
- Simultaneous cases in SET_S: up+down -> secs unchanged; mode+up -> COMMIT with secs unchanged; cancel+mode -> IDLE, no start. Reset asserted in SET_S -> all outputs 0, no start pulse.
- With CLOCK_SETTER_TIMEOUT_EN and TIMEOUT_CYCLES = 8: enter SET_H and apply no buttons -> IDLE after 8 cycles, no start. An up press at cycle 5 restarts the count.
